keypad_scanner: RTL

Matrix keypad controller. It sequences column drive across a ROWS×COLS key matrix and samples the row lines. It debounces every key in a shared, time-multiplexed filter and emits press/release events through a valid/ready FIFO. It sits between the board's keypad pins and any consumer of key events, such as a CPU peripheral bus wrapper. It replaces per-key debounce instances.

---
 rtl/keypad_pkg.sv | 19 +
 rtl/event_fifo.sv | 63 ++++++
 rtl/keypad_scanner.sv | 129 ++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared scan-state and key-event types for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, EVAL} scan_state_t;

    function automatic int key_width(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

    localparam int MAX_ROWS = 16;
    localparam int MAX_COLS = 16;
    localparam int KEY_W = key_width(MAX_ROWS, MAX_COLS);

    typedef struct packed {
        logic             press;
        logic [KEY_W-1:0] key;
    } key_event_t;

endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous key-event queue whose head is held in output registers
module event_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  key_event_t push_data,
    output logic       full,
    input  logic       pop,
    output logic       empty,
    output logic       out_valid,
    output key_event_t out_data
);

    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    key_event_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0] count, count_next;
    logic          do_push, do_pop;
    key_event_t    head_next;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;

    // An incoming event becomes the head directly when nothing older remains
    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        rd_next    = do_pop ? inc(rd_ptr) : rd_ptr;
        count_next = count + CW'(do_push) - CW'(do_pop);
        head_next  = (do_push && count == CW'(do_pop)) ? push_data : mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            wr_ptr    <= do_push ? inc(wr_ptr) : wr_ptr;
            rd_ptr    <= rd_next;
            count     <= count_next;
            out_valid <= count_next != '0;
            out_data  <= (count_next != '0) ? head_next : out_data;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanned matrix keypad with one time-shared debounce
// filter and a valid/ready press/release event queue
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    output logic [COLS-1:0]                  col_n,
    input  logic [ROWS-1:0]                  row_n,
    output logic [ROWS*COLS-1:0]             keys,
    output logic                             ev_valid,
    input  logic                             ev_ready,
    output logic                             ev_press,
    output logic [key_width(ROWS, COLS)-1:0] ev_key,
    output logic                             overflow
);

    localparam int NK  = ROWS * COLS;
    localparam int KW  = key_width(ROWS, COLS);
    localparam int RW  = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int CLW = COLS > 1 ? $clog2(COLS) : 1;
    localparam int DW  = $clog2(SCAN_DIV);
    localparam int NW  = $clog2(DEBOUNCE_SCANS + 1);

    scan_state_t     state;
    logic [ROWS-1:0] row_s1, row_s2, rowcap;
    logic [CLW-1:0]  c, c_next;
    logic [RW-1:0]   r;
    logic [DW-1:0]   div;
    logic [NW-1:0]   cnt [NK];
    logic [KW-1:0]   k;
    logic            differ, flip, pop, fifo_full, fifo_empty;
    key_event_t      push_ev, head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= row_n;
            row_s2 <= row_s1;
        end
    end

    always_comb begin
        k             = KW'(r) * KW'(COLS) + KW'(c);
        c_next        = (c == CLW'(COLS - 1)) ? '0 : c + 1'b1;
        differ        = rowcap[r] != keys[k];
        flip          = state == EVAL && differ && cnt[k] == NW'(DEBOUNCE_SCANS - 1);
        push_ev.press = !keys[k];
        push_ev.key   = KEY_W'(k);
        pop           = ev_ready && !fifo_empty;
    end

    // EVAL visits one row of the latched column per cycle, so a single
    // comparator and counter update serve every key in turn
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            col_n    <= '1;
            c        <= '0;
            r        <= '0;
            div      <= '0;
            rowcap   <= '0;
            keys     <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < NK; i++) cnt[i] <= '0;
        end else begin
            overflow <= flip && fifo_full && !pop;
            case (state)
                IDLE: begin
                    div   <= '0;
                    state <= enable ? DRIVE : IDLE;
                    col_n <= enable ? ~(COLS'(1) << c) : '1;
                end
                DRIVE: begin
                    if (div == DW'(SCAN_DIV - 1)) begin
                        rowcap <= ~row_s2;
                        div    <= '0;
                        r      <= '0;
                        state  <= EVAL;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: begin
                    if (!differ) begin
                        cnt[k] <= '0;
                    end else if (flip) begin
                        keys[k] <= !keys[k];
                        cnt[k]  <= '0;
                    end else begin
                        cnt[k] <= cnt[k] + 1'b1;
                    end
                    if (r == RW'(ROWS - 1)) begin
                        c     <= c_next;
                        state <= enable ? DRIVE : IDLE;
                        col_n <= enable ? ~(COLS'(1) << c_next) : '1;
                    end else begin
                        r <= r + 1'b1;
                    end
                end
            endcase
        end
    end

    event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (flip),
        .push_data (push_ev),
        .full      (fifo_full),
        .pop       (pop),
        .empty     (fifo_empty),
        .out_valid (ev_valid),
        .out_data  (head)
    );

    assign ev_press = head.press;
    assign ev_key   = KW'(head.key);

endmodule
